bpu_pred: RTL and testbench

- Parametrised dynamic branch predictor for the IF stage; successor to the combinational branch-resolution unit.
- Holds a direct-mapped BTB with one 2-bit saturating direction counter per entry, and returns a predicted taken flag and target for the fetch PC in the same cycle.
- Trained one cycle later from EX-stage resolution results (jump/branch, taken, target); supports bulk invalidate on fence.i / satp change.

---
 rtl/bpu_pred_pkg.sv | 34 +++
 rtl/bpu_cnt2.sv | 37 +++
 rtl/bpu_pred.sv | 117 +++++++++++
 tb/tb_bpu_pred.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pred_pkg.sv
// Shared types and helpers for the BTB-based branch predictor.
package bpu_pred_pkg;

  // 2-bit saturating direction counter states.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt2_t;

  localparam cnt2_t CNT_RST = WNT;

  // Saturating step toward taken (increment) or not-taken (decrement).
  function automatic cnt2_t cnt2_next(input cnt2_t cnt, input logic taken);
    cnt2_t nxt;
    nxt = cnt;
    if (taken) begin
      case (cnt)
        SNT:     nxt = WNT;
        WNT:     nxt = WT;
        default: nxt = ST;
      endcase
    end else begin
      case (cnt)
        ST:      nxt = WT;
        WT:      nxt = WNT;
        default: nxt = SNT;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bpu_cnt2.sv
// One 2-bit saturating direction counter with load and inc/dec.
module bpu_cnt2
  import bpu_pred_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  load_en,
  input  cnt2_t load_val,
  input  logic  step_en,
  input  logic  taken,
  output cnt2_t cnt_o
);

  cnt2_t cnt_d, cnt_q;

  // Load has priority over a saturating step; otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_en) begin
      cnt_d = load_val;
    end else if (step_en) begin
      cnt_d = cnt2_next(cnt_q, taken);
    end
  end

  // Counter state, reset to weakly-not-taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= CNT_RST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bpu_pred.sv
// Direct-mapped BTB branch predictor: same-cycle lookup, registered training.
module bpu_pred
  import bpu_pred_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ENTRY = 16,
  parameter int IDX_W = $clog2(ENTRY),
  parameter int TAG_W = XLEN - IDX_W - 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic            upd_jump,
  input  logic            upd_branch,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            flush_all
);

  logic [IDX_W-1:0] pidx, uidx;
  logic [TAG_W-1:0] ptag, utag;

  logic [ENTRY-1:0] valid_d, valid_q;
  logic [TAG_W-1:0] tag_d    [ENTRY];
  logic [TAG_W-1:0] tag_q    [ENTRY];
  logic [XLEN-1:0]  target_d [ENTRY];
  logic [XLEN-1:0]  target_q [ENTRY];
  cnt2_t            cnt_w    [ENTRY];

  logic [ENTRY-1:0] load_en, step_en;
  logic             upd_en, upd_eff_taken, upd_hit;
  logic             upd_alloc, upd_wr_tgt, cnt_load, cnt_step;
  cnt2_t            cnt_load_val;

  // pc[1:0] never participates in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0]};

  assign pidx = pred_pc[IDX_W+1:2];
  assign ptag = pred_pc[XLEN-1:IDX_W+2];
  assign uidx = upd_pc[IDX_W+1:2];
  assign utag = upd_pc[XLEN-1:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign pred_hit    = valid_q[pidx] && (tag_q[pidx] == ptag);
  assign pred_taken  = pred_hit && cnt_w[pidx][1];
  assign pred_target = pred_hit ? target_q[pidx] : '0;

  // Flush suppresses any coincident training write.
  assign upd_en        = upd_valid && (upd_jump || upd_branch) && !flush_all;
  assign upd_eff_taken = upd_jump || upd_taken;
  assign upd_hit       = valid_q[uidx] && (tag_q[uidx] == utag);
  assign upd_alloc     = upd_en && !upd_hit && upd_eff_taken;
  assign upd_wr_tgt    = upd_en && upd_eff_taken;
  // Fresh allocations and any jump hit load the counter outright.
  assign cnt_load      = upd_en && upd_eff_taken && (!upd_hit || upd_jump);
  assign cnt_step      = upd_en && upd_hit && !upd_jump;
  assign cnt_load_val  = upd_jump ? ST : WT;

  // Next-state for valid/tag/target and per-entry counter controls.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    load_en  = '0;
    step_en  = '0;
    if (flush_all) begin
      valid_d = '0;
    end
    for (int i = 0; i < ENTRY; i++) begin
      if (uidx == IDX_W'(i)) begin
        if (upd_alloc) begin
          valid_d[i] = 1'b1;
          tag_d[i]   = utag;
        end
        if (upd_wr_tgt) begin
          target_d[i] = upd_target;
        end
        load_en[i] = cnt_load;
        step_en[i] = cnt_step;
      end
    end
  end

  // BTB valid/tag/target storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRY; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  for (genvar g = 0; g < ENTRY; g++) begin : g_cnt
    bpu_cnt2 u_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .load_en  (load_en[g]),
      .load_val (cnt_load_val),
      .step_en  (step_en[g]),
      .taken    (upd_taken),
      .cnt_o    (cnt_w[g])
    );
  end

endmodule

// File: tb/tb_bpu_pred.sv
// Self-checking bench for bpu_pred: directed scenarios plus random training.
module tb_bpu_pred;

  localparam int XLEN  = 32;
  localparam int ENTRY = 16;
  localparam int IDX_W = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [XLEN-1:0] pred_pc;
  logic            pred_hit, pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid, upd_jump, upd_branch, upd_taken, flush_all;
  logic [XLEN-1:0] upd_pc, upd_target;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference BTB: per-slot state with counter as integer 0..3.
  bit          m_valid  [ENTRY];
  int unsigned m_tag    [ENTRY];
  int unsigned m_target [ENTRY];
  int          m_cnt    [ENTRY];

  bpu_pred #(.XLEN(XLEN), .ENTRY(ENTRY)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .pred_pc     (pred_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_jump    (upd_jump),
    .upd_branch  (upd_branch),
    .upd_taken   (upd_taken),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .flush_all   (flush_all)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int slot(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % ENTRY);
  endfunction

  function automatic int unsigned tagof(input logic [XLEN-1:0] pc);
    return pc / (4 * ENTRY);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRY; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 0; m_cnt[i] = 1;
    end
  endtask

  // Apply the training rules to the model using the inputs held at this edge.
  task automatic model_update();
    int  s;
    bit  hit, tk;
    if (flush_all) begin
      for (int i = 0; i < ENTRY; i++) m_valid[i] = 1'b0;
    end else if (upd_valid && (upd_jump || upd_branch)) begin
      s   = slot(upd_pc);
      hit = m_valid[s] && (m_tag[s] == tagof(upd_pc));
      tk  = upd_jump || upd_taken;
      if (hit) begin
        if (upd_jump)  m_cnt[s] = 3;
        else if (tk)   m_cnt[s] = (m_cnt[s] < 3) ? m_cnt[s] + 1 : 3;
        else           m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
        if (tk) m_target[s] = upd_target;
      end else if (tk) begin
        m_valid[s]  = 1'b1;
        m_tag[s]    = tagof(upd_pc);
        m_target[s] = upd_target;
        m_cnt[s]    = upd_jump ? 3 : 2;
      end
    end
  endtask

  task automatic check_lookup(input string name);
    int          s;
    logic        e_hit, e_taken;
    logic [XLEN-1:0] e_tgt;
    s       = slot(pred_pc);
    e_hit   = m_valid[s] && (m_tag[s] == tagof(pred_pc));
    e_taken = e_hit && (m_cnt[s] >= 2);
    e_tgt   = e_hit ? m_target[s] : '0;
    n_checks++;
    assert (pred_hit === e_hit) else begin
      n_fail++;
      $error("FAIL %s hit pc=%h: got %b expected %b", name, pred_pc, pred_hit, e_hit);
    end
    n_checks++;
    assert (pred_taken === e_taken) else begin
      n_fail++;
      $error("FAIL %s taken pc=%h: got %b expected %b", name, pred_pc, pred_taken, e_taken);
    end
    n_checks++;
    assert (pred_target === e_tgt) else begin
      n_fail++;
      $error("FAIL %s target pc=%h: got %h expected %h", name, pred_pc, pred_target, e_tgt);
    end
  endtask

  // Direct check of a single output against a fixed expectation.
  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic [XLEN-1:0] ppc, input logic uv, input logic uj,
                       input logic ub, input logic ut, input logic [XLEN-1:0] upc,
                       input logic [XLEN-1:0] utgt, input logic fl);
    pred_pc = ppc; upd_valid = uv; upd_jump = uj; upd_branch = ub;
    upd_taken = ut; upd_pc = upc; upd_target = utgt; flush_all = fl;
  endtask

  // Called at a negedge: settle, check lookup, clock, advance model.
  task automatic step(input string name);
    #1;
    check_lookup(name);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_look(input logic [XLEN-1:0] ppc, input string name);
    drive(ppc, 0, 0, 0, 0, '0, '0, 0);
    step(name);
  endtask

  logic [XLEN-1:0] rpc, rupc;

  initial begin
    model_reset();
    drive(32'h100, 0, 0, 0, 0, '0, '0, 0);
    rstn = 1'b0;
    #12;
    check_lookup("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Branch allocation lands in WT.
    drive(32'h100, 1, 0, 1, 1, 32'h100, 32'h80, 0);
    step("alloc_same_cycle");
    idle_look(32'h100, "alloc_branch");
    check_bit("alloc_branch_taken_wt", pred_taken, 1'b1);

    // Not-taken training to SNT, then saturation.
    drive(32'h100, 1, 0, 1, 0, 32'h100, 32'h0, 0);
    step("nt1");
    drive(32'h100, 1, 0, 1, 0, 32'h100, 32'h0, 0);
    step("nt2");
    idle_look(32'h100, "at_snt");
    drive(32'h100, 1, 0, 1, 0, 32'h100, 32'h0, 0);
    step("nt3");
    drive(32'h100, 1, 0, 1, 1, 32'h100, 32'h84, 0);
    step("t_from_snt");
    idle_look(32'h100, "snt_saturated");

    // Upd_valid with neither flag set is a no-op.
    drive(32'h104, 1, 0, 0, 1, 32'h104, 32'h999, 0);
    step("noop_upd");
    idle_look(32'h104, "noop_after");

    // Alias: jump at 0x140 replaces 0x100 in slot 0.
    drive(32'h140, 1, 1, 0, 0, 32'h140, 32'h400, 0);
    step("alias_same_cycle");
    idle_look(32'h100, "alias_old_miss");
    idle_look(32'h140, "alias_new_hit");
    check_bit("alias_jump_st", pred_taken, 1'b1);

    // Empty the BTB, then same-cycle lookup+update at 0x200.
    drive(32'h0, 0, 0, 0, 0, '0, '0, 1);
    step("flush_plain");
    drive(32'h200, 1, 0, 1, 1, 32'h200, 32'h240, 0);
    #1;
    check_bit("no_bypass_hit", pred_hit, 1'b0);
    step("no_bypass");
    idle_look(32'h200, "visible_next");
    check_bit("visible_next_hit", pred_hit, 1'b1);

    // Flush wins over a coincident update.
    drive(32'h100, 1, 1, 0, 0, 32'h100, 32'h500, 0);
    step("reprogram_100");
    drive(32'h300, 1, 1, 0, 0, 32'h300, 32'h600, 1);
    step("flush_with_upd");
    idle_look(32'h300, "flush_300_miss");
    check_bit("flush_300_hit", pred_hit, 1'b0);
    idle_look(32'h100, "flush_100_miss");
    idle_look(32'h200, "flush_200_miss");

    // Reset arriving while an update is presented discards the write.
    drive(32'h500, 1, 1, 0, 0, 32'h500, 32'h700, 0);
    #2;
    rstn = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    drive(32'h500, 0, 0, 0, 0, '0, '0, 0);
    rstn = 1'b1;
    step("reset_mid_update");

    // Random training over a small tag pool to exercise hits and aliasing.
    for (int n = 0; n < 600; n++) begin
      rupc = ($urandom_range(0, 2) << (IDX_W + 2)) | ($urandom_range(0, ENTRY - 1) << 2)
             | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) rpc = rupc;
      else rpc = ($urandom_range(0, 2) << (IDX_W + 2)) | ($urandom_range(0, ENTRY - 1) << 2)
                 | $urandom_range(0, 3);
      drive(rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rupc,
            $urandom, $urandom_range(0, 49) == 0);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
